// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches 24-bit microinstructions from a synchronous
// control ROM and issues their control fields, with inc/branch/map/halt sequencing.
module micro_sequencer #(
  parameter logic [5:0] START_ADDR = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  ir_op,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic [23:0] uinst,
  output logic [5:0]  uaddr,
  output logic [13:0] ctrl,
  output logic        ctrl_valid,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_upc;
  logic        r_single;
  logic [13:0] r_ctrl;
  logic        r_ctrl_valid;
  logic        r_busy;
  logic        r_halted;

  logic [1:0]  w_seq_op;
  logic [1:0]  w_cond_sel;
  logic [5:0]  w_next_field;
  logic [5:0]  w_upc_inc;
  logic        w_cond_true;
  logic [5:0]  w_next_upc;

  assign w_seq_op     = uinst[9:8];
  assign w_cond_sel   = uinst[7:6];
  assign w_next_field = uinst[5:0];
  assign w_upc_inc    = r_upc + 6'd1;

  // Branch condition selected by the microinstruction
  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond_sel)
      2'b00:   w_cond_true = 1'b1;
      2'b01:   w_cond_true = flag_z;
      2'b10:   w_cond_true = flag_c;
      2'b11:   w_cond_true = ~flag_z;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Next microaddress; a halt keeps upc where it is
  always_comb begin
    w_next_upc = w_upc_inc;
    case (w_seq_op)
      2'b00: w_next_upc = w_upc_inc;
      2'b01: begin
        if (w_cond_true) begin
          w_next_upc = w_next_field;
        end else begin
          w_next_upc = w_upc_inc;
        end
      end
      2'b10:   w_next_upc = {ir_op, 2'b00};
      2'b11:   w_next_upc = r_upc;
      default: w_next_upc = w_upc_inc;
    endcase
  end

  // Sequencer FSM with registered status and control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_upc        <= START_ADDR;
      r_single     <= 1'b0;
      r_ctrl       <= 14'h0000;
      r_ctrl_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state  <= S_FETCH;
            r_single <= 1'b0;
            r_busy   <= 1'b1;
          end else if (step) begin
            r_state  <= S_FETCH;
            r_single <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state <= S_EXEC;
          r_busy  <= 1'b1;
        end
        S_EXEC: begin
          r_ctrl       <= uinst[23:10];
          r_ctrl_valid <= 1'b1;
          if (w_seq_op == 2'b11) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_upc <= w_next_upc;
            // run must still be high and no single-step pending to keep going
            if (run && !r_single) begin
              r_state <= S_FETCH;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_single <= 1'b0;
            end
          end
        end
        S_HALT: begin
          r_state  <= S_HALT;
          r_busy   <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
          r_single <= 1'b0;
        end
      endcase
    end
  end

  assign uaddr      = r_upc;
  assign ctrl       = r_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign busy       = r_busy;
  assign halted     = r_halted;

endmodule
